// File: rtl/rtc_bus_writer_pkg.sv
// Shared constants and types for the RTC bus writer: register map, idle bus values,
// FSM state encodings and the write-list address lookup.
package rtc_bus_writer_pkg;

   localparam logic [7:0] AddrSeg     = 8'h21;
   localparam logic [7:0] AddrMin     = 8'h22;
   localparam logic [7:0] AddrHora    = 8'h23;
   localparam logic [7:0] AddrDia     = 8'h24;
   localparam logic [7:0] AddrMes     = 8'h25;
   localparam logic [7:0] AddrYear    = 8'h26;
   localparam logic [7:0] AddrSegCr   = 8'h41;
   localparam logic [7:0] AddrMinCr   = 8'h42;
   localparam logic [7:0] AddrHoraCr  = 8'h43;
   localparam logic [7:0] AddrCmdRead = 8'hF0;
   localparam logic [7:0] AddrCmdClk  = 8'hF1;
   localparam logic [7:0] AddrCmdTmr  = 8'hF2;

   localparam logic [7:0] BusIdle    = 8'hFF;
   localparam logic       StrobeIdle = 1'b1;

   typedef enum logic [2:0] {
      StIdle, StAAd, StAPhase, StAAdh, StGap, StDPhase, StNext, StDone
   } state_t;

   typedef enum logic [2:0] {
      PhIdle, PhCs, PhWr, PhWrh, PhCsh
   } phase_t;

   // The final index of each list is the command-only entry.
   function automatic logic entry_is_cmd(input logic mode, input logic [2:0] idx);
      return mode ? (idx >= 3'd3) : (idx >= 3'd6);
   endfunction

   function automatic logic [7:0] entry_addr(input logic mode, input logic [2:0] idx);
      logic [7:0] a;
      if (mode) begin
         case (idx)
            3'd0:    a = AddrSegCr;
            3'd1:    a = AddrMinCr;
            3'd2:    a = AddrHoraCr;
            default: a = AddrCmdTmr;
         endcase
      end else begin
         case (idx)
            3'd0:    a = AddrSeg;
            3'd1:    a = AddrMin;
            3'd2:    a = AddrHora;
            3'd3:    a = AddrDia;
            3'd4:    a = AddrMes;
            3'd5:    a = AddrYear;
            default: a = AddrCmdClk;
         endcase
      end
      return a;
   endfunction

endpackage

// File: rtl/rtc_bus_writer_phase.sv
// Single write-strobe sequencer: cs low, wr low for HOLD cycles, wr high, cs high.
// Used for both the address and the data phase of a transaction.
module rtc_bus_phase
   import rtc_bus_writer_pkg::*;
#(
   parameter int unsigned HOLD = 6
) (
   input  logic clock,
   input  logic reset,
   input  logic go,
   output logic cs,
   output logic wr,
   output logic last
);

   phase_t     ph_q, ph_d;
   logic [7:0] cnt_q, cnt_d;

   always_ff @(posedge clock) begin
      if (!reset) begin
         ph_q  <= PhIdle;
         cnt_q <= '0;
      end else begin
         ph_q  <= ph_d;
         cnt_q <= cnt_d;
      end
   end

   always_comb begin
      ph_d  = ph_q;
      cnt_d = cnt_q;
      cs    = StrobeIdle;
      wr    = StrobeIdle;
      last  = 1'b0;
      case (ph_q)
         PhIdle: if (go) ph_d = PhCs;
         PhCs: begin
            cs    = 1'b0;
            cnt_d = '0;
            ph_d  = PhWr;
         end
         PhWr: begin
            cs    = 1'b0;
            wr    = 1'b0;
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == 8'(HOLD - 1)) ph_d = PhWrh;
         end
         PhWrh: begin
            cs   = 1'b0;
            ph_d = PhCsh;
         end
         PhCsh: begin
            last = 1'b1;
            ph_d = PhIdle;
         end
         default: ph_d = PhIdle;
      endcase
   end

endmodule

// File: rtl/rtc_bus_writer.sv
// RTC bus writer: latches clock/date or timer values on a start edge and writes them
// to the RTC one register per transaction, followed by a commit command address.
module rtc_bus_writer
   import rtc_bus_writer_pkg::*;
#(
   parameter int unsigned HOLD = 6,
   parameter int unsigned GAP  = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic       mode,
   input  logic [7:0] seg,
   input  logic [7:0] min,
   input  logic [7:0] hora,
   input  logic [7:0] dia,
   input  logic [7:0] mes,
   input  logic [7:0] year,
   input  logic       AmPm,
   input  logic [7:0] segcrono,
   input  logic [7:0] mincrono,
   input  logic [7:0] horacrono,
   output logic [7:0] ADout,
   output logic       drive_en,
   output logic       ad,
   output logic       wr,
   output logic       rd,
   output logic       cs,
   output logic       busy,
   output logic       done
);

   state_t          state_q, state_d;
   logic [2:0]      index_q, index_d;
   logic [7:0]      gap_q, gap_d;
   logic            start_q;
   logic            mode_q;
   logic [5:0][7:0] data_q;
   logic            load;
   logic            go;
   logic            ph_last;
   logic [7:0]      addr;
   logic [7:0]      data_byte;
   logic            is_cmd;

   rtc_bus_phase #(
      .HOLD(HOLD)
   ) u_phase (
      .clock(clock),
      .reset(reset),
      .go   (go),
      .cs   (cs),
      .wr   (wr),
      .last (ph_last)
   );

   assign rd     = StrobeIdle;
   assign addr   = entry_addr(mode_q, index_q);
   assign is_cmd = entry_is_cmd(mode_q, index_q);

   always_comb begin
      case (index_q)
         3'd0:    data_byte = data_q[0];
         3'd1:    data_byte = data_q[1];
         3'd2:    data_byte = data_q[2];
         3'd3:    data_byte = data_q[3];
         3'd4:    data_byte = data_q[4];
         3'd5:    data_byte = data_q[5];
         default: data_byte = BusIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= StIdle;
         index_q <= '0;
         gap_q   <= '0;
         start_q <= 1'b0;
         mode_q  <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         index_q <= index_d;
         gap_q   <= gap_d;
         start_q <= start;
         if (load) begin
            mode_q <= mode;
            // Timer list only uses the first three slots.
            data_q <= mode ? {24'h0, horacrono, mincrono, segcrono}
                           : {year, mes, dia, {AmPm, hora[6:0]}, min, seg};
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      index_d  = index_q;
      gap_d    = gap_q;
      load     = 1'b0;
      go       = 1'b0;
      ad       = StrobeIdle;
      ADout    = BusIdle;
      drive_en = 1'b0;
      busy     = 1'b1;
      done     = 1'b0;
      case (state_q)
         StIdle: begin
            busy    = 1'b0;
            index_d = '0;
            if (start && !start_q) begin
               load    = 1'b1;
               state_d = StAAd;
            end
         end
         StAAd: begin
            ad       = 1'b0;
            ADout    = addr;
            drive_en = 1'b1;
            go       = 1'b1;
            state_d  = StAPhase;
         end
         StAPhase: begin
            ad       = 1'b0;
            ADout    = addr;
            drive_en = 1'b1;
            if (ph_last) state_d = StAAdh;
         end
         StAAdh: begin
            // A command entry releases the bus here; it has no data phase.
            if (!is_cmd) begin
               ADout    = addr;
               drive_en = 1'b1;
            end
            gap_d   = '0;
            state_d = is_cmd ? StNext : StGap;
         end
         StGap: begin
            ADout    = addr;
            drive_en = 1'b1;
            gap_d    = gap_q + 8'd1;
            if (gap_q == 8'(GAP - 1)) begin
               go      = 1'b1;
               state_d = StDPhase;
            end
         end
         StDPhase: begin
            if (!ph_last) begin
               ADout    = data_byte;
               drive_en = 1'b1;
            end else begin
               state_d = StNext;
            end
         end
         StNext: begin
            if (is_cmd) begin
               state_d = StDone;
            end else begin
               index_d = index_q + 3'd1;
               state_d = StAAd;
            end
         end
         StDone: begin
            busy    = 1'b0;
            done    = 1'b1;
            index_d = '0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

endmodule

// File: tb/tb_rtc_bus_writer.sv
// Directed bench for rtc_bus_writer: a bus monitor decodes every wr pulse into
// address/data bytes and checks them against a scoreboard plus strobe timing rules.
module tb_rtc_bus_writer;

   localparam int unsigned HOLD = 6;
   localparam int unsigned GAP  = 2;

   logic       clock = 1'b0;
   logic       reset;
   logic       start;
   logic       mode;
   logic [7:0] seg, min, hora, dia, mes, year;
   logic       AmPm;
   logic [7:0] segcrono, mincrono, horacrono;
   logic [7:0] ADout;
   logic       drive_en, ad, wr, rd, cs, busy, done;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   logic [8:0] sb[$];  // {is_address, byte}

   rtc_bus_writer #(
      .HOLD(HOLD),
      .GAP (GAP)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .start    (start),
      .mode     (mode),
      .seg      (seg),
      .min      (min),
      .hora     (hora),
      .dia      (dia),
      .mes      (mes),
      .year     (year),
      .AmPm     (AmPm),
      .segcrono (segcrono),
      .mincrono (mincrono),
      .horacrono(horacrono),
      .ADout    (ADout),
      .drive_en (drive_en),
      .ad       (ad),
      .wr       (wr),
      .rd       (rd),
      .cs       (cs),
      .busy     (busy),
      .done     (done)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Bus monitor
   bit         in_pulse = 0;
   bit         pulse_addr;
   bit         stable;
   logic [7:0] pulse_byte;
   int         pulse_len;
   int         de_viol = 0;
   int         rd_viol = 0;
   int         ad_falls = 0;
   logic       ad_prev = 1'b1;
   logic [8:0] exp_e;

   always @(negedge clock) begin
      if (rd !== 1'b1) rd_viol++;
      if (ADout !== 8'hFF && drive_en !== 1'b1) de_viol++;
      if (ad_prev === 1'b1 && ad === 1'b0) ad_falls++;
      ad_prev = ad;
      if (!reset) begin
         in_pulse = 0;
      end else if (wr === 1'b0) begin
         if (!in_pulse) begin
            in_pulse   = 1;
            pulse_len  = 0;
            pulse_byte = ADout;
            pulse_addr = (ad === 1'b0);
            stable     = 1;
         end
         pulse_len++;
         if (ADout !== pulse_byte || cs !== 1'b0) stable = 0;
      end else if (in_pulse) begin
         in_pulse = 0;
         chk("wr_low_cycles", pulse_len, HOLD);
         chk("cs_low_adout_stable", stable, 1);
         if (sb.size() == 0) begin
            chk("unexpected_txn", {pulse_addr, pulse_byte}, 9'h1FF);
         end else begin
            exp_e = sb.pop_front();
            chk(pulse_addr ? "addr_byte" : "data_byte", {pulse_addr, pulse_byte}, exp_e);
         end
      end
   end

   task automatic check_idle(input string tag);
      chk({tag, "_ad"}, ad, 1);
      chk({tag, "_wr"}, wr, 1);
      chk({tag, "_rd"}, rd, 1);
      chk({tag, "_cs"}, cs, 1);
      chk({tag, "_adout"}, ADout, 8'hFF);
      chk({tag, "_drive_en"}, drive_en, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
   endtask

   task automatic push_pair(input logic [7:0] a, input logic [7:0] d);
      sb.push_back({1'b1, a});
      sb.push_back({1'b0, d});
   endtask

   task automatic push_mode0(input logic [7:0] s, input logic [7:0] mi, input logic [7:0] h,
                             input logic ap, input logic [7:0] di, input logic [7:0] me,
                             input logic [7:0] y);
      push_pair(8'h21, s);
      push_pair(8'h22, mi);
      push_pair(8'h23, {ap, h[6:0]});
      push_pair(8'h24, di);
      push_pair(8'h25, me);
      push_pair(8'h26, y);
      sb.push_back({1'b1, 8'hF1});
   endtask

   // Times from the first address strobe to the done pulse.
   task automatic run_and_time(input string tag, input int exp_lat);
      int t0, t1;
      bit found;
      found = 0;
      t0 = 0;
      t1 = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (ad === 1'b0) begin
            found = 1;
            t0 = cyc;
            break;
         end
      end
      if (!found) begin
         chk({tag, "_no_address_phase"}, 0, 1);
         return;
      end
      found = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clock);
         if (done === 1'b1) begin
            found = 1;
            t1 = cyc;
            break;
         end
      end
      if (!found) chk({tag, "_done_timeout"}, 0, 1);
      else chk({tag, "_latency"}, t1 - t0, exp_lat);
      chk({tag, "_scoreboard_drained"}, sb.size(), 0);
   endtask

   task automatic set_mode0_vals();
      mode = 1'b0;
      seg  = 8'h45;
      min  = 8'h30;
      hora = 8'h11;
      AmPm = 1'b1;
      dia  = 8'h23;
      mes  = 8'h03;
      year = 8'h16;
   endtask

   task automatic pulse_start();
      @(posedge clock);
      #1 start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
   endtask

   int falls_before;

   initial begin
      reset     = 1'b0;
      start     = 1'b0;
      mode      = 1'b0;
      seg       = 8'h00;
      min       = 8'h00;
      hora      = 8'h00;
      dia       = 8'h00;
      mes       = 8'h00;
      year      = 8'h00;
      AmPm      = 1'b0;
      segcrono  = 8'h00;
      mincrono  = 8'h00;
      horacrono = 8'h00;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check_idle("reset");
      #1 reset = 1'b1;

      // Abort a sequence part-way with reset held low for three cycles.
      set_mode0_vals();
      push_mode0(seg, min, hora, AmPm, dia, mes, year);
      pulse_start();
      repeat (40) @(posedge clock);
      #1 reset = 1'b0;
      sb.delete();
      @(posedge clock);
      @(negedge clock);
      check_idle("abort");
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
      @(negedge clock);
      check_idle("after_abort");

      // Mode 0 full run; inputs scrambled right after the start edge is taken.
      set_mode0_vals();
      push_mode0(8'h45, 8'h30, 8'h11, 1'b1, 8'h23, 8'h03, 8'h16);
      @(posedge clock);
      #1 start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      seg  = 8'($urandom);
      min  = 8'($urandom);
      hora = 8'($urandom);
      AmPm = 1'b0;
      dia  = 8'($urandom);
      mes  = 8'($urandom);
      year = 8'($urandom);
      mode = 1'b1;
      run_and_time("mode0", 150);
      @(negedge clock);
      check_idle("mode0_end");

      // Mode 1 with start held high and a second edge while busy.
      mode      = 1'b1;
      segcrono  = 8'h59;
      mincrono  = 8'h07;
      horacrono = 8'h02;
      push_pair(8'h41, 8'h59);
      push_pair(8'h42, 8'h07);
      push_pair(8'h43, 8'h02);
      sb.push_back({1'b1, 8'hF2});
      @(posedge clock);
      #1 start = 1'b1;
      fork
         run_and_time("mode1", 81);
         begin
            repeat (30) @(posedge clock);
            #1 start = 1'b0;
            @(posedge clock);
            #1 start = 1'b1;
         end
      join
      falls_before = ad_falls;
      repeat (200) @(negedge clock);
      chk("single_sequence_extra_addr", ad_falls - falls_before, 0);
      chk("single_sequence_busy", busy, 0);
      start = 1'b0;

      chk("drive_en_when_adout_valid", de_viol, 0);
      chk("rd_always_high", rd_viol, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rtc_bus_writer.md
Name: rtc_bus_writer

Overview:
- Programs the external RTC over the same multiplexed address/data bus (ad, wr, rd, cs, 8-bit AD) that the RTC reader block polls.
- On a start request it latches a set of BCD time/date or timer values, then writes them one register per transaction.
- After the data registers it issues a transfer command address so the RTC commits them.
- Sits beside the reader. The top level arbitrates the shared bus using busy; the reader is held off while busy=1.

Parameters:
- HOLD, 6: cycles that wr stays low in each address or data strobe (must be >=1).
- GAP, 2: cycles between address-phase release and data-phase assertion (must be >=1).

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  write request; its rising edge (start=1, previous sample 0) starts a sequence
- mode  in  1  0 = write clock/date block, 1 = write timer block
- seg, min, hora, dia, mes, year  in  8 each  BCD clock/date values
- AmPm  in  1  merged into hours bit 7
- segcrono, mincrono, horacrono  in  8 each  BCD timer values
- ADout  out  8  bus drive value, 8'hFF when not driving
- drive_en  out  1  1 while ADout carries a valid address or data byte (tristate enable)
- ad  out  1  address strobe, active low
- wr  out  1  write strobe, active low
- rd  out  1  read strobe, held 1 at all times by this block
- cs  out  1  chip select, active low
- busy  out  1  1 from start detection until done
- done  out  1  one-cycle pulse after the final transaction

Behaviour:
- Reset values (reset=0 at a clock edge): ad=wr=rd=cs=1, ADout=8'hFF, drive_en=0, busy=0, done=0, state=IDLE, index=0, start edge register=0.
- Reset mid-sequence aborts immediately. Outputs take their reset values on the next edge; no partial transaction is completed.
- IDLE: outputs at idle values.
  - On a start rising edge, latch all value inputs and mode, set busy=1, index=0, and go to A_AD.
  - Start edges while busy=1 are ignored. Input changes after latching have no effect.
- Write list, mode 0, in order:
  - 0x21 ← seg
  - 0x22 ← min
  - 0x23 ← {AmPm, hora[6:0]}
  - 0x24 ← dia
  - 0x25 ← mes
  - 0x26 ← year
  - then command-only address 0xF1
- Write list, mode 1, in order:
  - 0x41 ← segcrono
  - 0x42 ← mincrono
  - 0x43 ← horacrono
  - then command-only address 0xF2
- States and their actions. Each state lasts 1 cycle unless noted.
  - A_AD: ad=0, ADout=addr, drive_en=1.
  - A_CS: cs=0.
  - A_WR: wr=0 for HOLD cycles.
  - A_WRH: wr=1.
  - A_CSH: cs=1.
  - A_ADH: ad=1. If the entry is a command, set ADout=FF, drive_en=0 and go to NEXT; otherwise go to GAP.
  - GAP: GAP cycles, ADout held at the address.
  - D_CS: ADout=data, cs=0; ad stays 1.
  - D_WR: wr=0 for HOLD cycles.
  - D_WRH: wr=1.
  - D_CSH: cs=1, ADout=FF, drive_en=0.
  - NEXT: if the entry was the command, go to DONE; else index+1 and go to A_AD.
  - DONE: done=1, busy=0, then go to IDLE.
- Strobe invariants:
  - wr is never low while cs is high.
  - ad and wr never change on the same edge.
  - ADout is stable throughout any interval where wr=0.
- Latency with defaults, counted from the first A_AD cycle:
  - data transaction = 9+2·HOLD+GAP = 23 cycles
  - command transaction = 6+HOLD = 12 cycles
  - mode 0 total = 6·23+12 = 150 cycles, then DONE
  - mode 1 total = 3·23+12 = 81 cycles, then DONE
- The index counter runs 0..6 in mode 0 and 0..3 in mode 1, and returns to 0 in IDLE. No wrap-around is possible.

Decomposition:
- Shared package:
  - RTC address constants (0x21–0x26, 0x41–0x43, 0xF0, 0xF1, 0xF2).
  - IDLE bus values (ADout=8'hFF, strobes=1).
  - State enum.
- Sub-module rtc_bus_phase: a single write strobe sequencer (cs→wr low HOLD cycles→wr→cs), reused for both the address and data phases.
- The top level owns the write list, latching and sequencing.

Test Plan:
- Reset held low 3 cycles mid-sequence → next edge ad=wr=rd=cs=1, ADout=FF, busy=0, done=0; a later start runs a full sequence from index 0.
- mode=0, seg=0x45, min=0x30, hora=0x11, AmPm=1, dia=0x23, mes=0x03, year=0x16, single start pulse → address/data pairs (21,45)(22,30)(23,91)(24,23)(25,03)(26,16), then command F1 with no data phase; done pulses 150 cycles after the first A_AD.
- mode=1, segcrono=0x59, mincrono=0x07, horacrono=0x02 → (41,59)(42,07)(43,02) then F2; done after 81 cycles; rd=1 throughout.
- Start held high continuously, plus a second start pulse while busy → exactly one sequence runs.
- Change every value input one cycle after start → written bytes equal the values latched at start.
- Protocol monitor on every transaction → wr low exactly HOLD cycles, cs low across wr low, ADout stable whenever wr=0, drive_en=1 whenever ADout≠FF.
